// File: rtl/bus_slave_port.sv
// Serial slave port: shifts in address/write data, issues one memory request per beat, shifts read data out MSB first.
// Latency: ADN (+N) serial cycles to request, then mem_ack wait; stalls on validIn=0, holds request until mem_ack.
module bus_slave_port #(
    parameter int ADN = 12,
    parameter int N   = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           validIn,
    input  logic           wren,
    input  logic           Address,
    input  logic           DataIn,
    input  logic           BurstEn,
    output logic           ready,
    output logic           validOut,
    output logic           DataOut,
    output logic [ADN-1:0] mem_addr,
    output logic [N-1:0]   mem_wdata,
    output logic           mem_we,
    output logic           mem_re,
    input  logic [N-1:0]   mem_rdata,
    input  logic           mem_ack,
    output logic [2:0]     state_out
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_WDATA  = 3'd2;
    localparam logic [2:0] S_MEMREQ = 3'd3;
    localparam logic [2:0] S_RDATA  = 3'd4;

    localparam int             CW        = $clog2(((ADN > N) ? ADN : N) + 1);
    localparam logic [CW-1:0]  ADDR_LAST = CW'(ADN - 1);
    localparam logic [CW-1:0]  DATA_LAST = CW'(N - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [ADN-1:0] ADDR_INC  = ADN'(1);

    logic [2:0]     r_state;
    logic [2:0]     w_next;
    logic [CW-1:0]  r_cnt;
    logic [ADN-1:0] r_addr;
    logic [N-1:0]   r_wdata;
    logic [N-1:0]   r_rdata;
    logic           r_wren;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (validIn) w_next = S_ADDR;
            S_ADDR:   if (validIn && (r_cnt == ADDR_LAST)) w_next = r_wren ? S_WDATA : S_MEMREQ;
            S_WDATA:  if (validIn && (r_cnt == DATA_LAST)) w_next = S_MEMREQ;
            S_MEMREQ: begin
                if (mem_ack) begin
                    if (!r_wren)      w_next = S_RDATA;
                    else if (BurstEn) w_next = S_WDATA;
                    else              w_next = S_IDLE;
                end
            end
            S_RDATA:  if (r_cnt == DATA_LAST) w_next = BurstEn ? S_MEMREQ : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready     = (r_state == S_IDLE);
        validOut  = (r_state == S_RDATA);
        DataOut   = validOut & r_rdata[N-1];
        mem_we    = (r_state == S_MEMREQ) &  r_wren;
        mem_re    = (r_state == S_MEMREQ) & ~r_wren;
        state_out = r_state;
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    // Burst beats reuse r_addr in place; the increment wraps naturally at ADN bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wren  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (validIn) begin
                        r_addr <= {{(ADN-1){1'b0}}, Address};
                        r_wren <= wren;
                        r_cnt  <= CNT_ONE;
                    end
                end
                S_ADDR: begin
                    if (validIn) begin
                        r_addr <= {r_addr[ADN-2:0], Address};
                        r_cnt  <= (r_cnt == ADDR_LAST) ? '0 : r_cnt + CNT_ONE;
                    end
                end
                S_WDATA: begin
                    if (validIn) begin
                        r_wdata <= {r_wdata[N-2:0], DataIn};
                        r_cnt   <= (r_cnt == DATA_LAST) ? '0 : r_cnt + CNT_ONE;
                    end
                end
                S_MEMREQ: begin
                    if (mem_ack) begin
                        r_cnt <= '0;
                        if (!r_wren)      r_rdata <= mem_rdata;
                        else if (BurstEn) r_addr  <= r_addr + ADDR_INC;
                    end
                end
                S_RDATA: begin
                    r_rdata <= {r_rdata[N-2:0], 1'b0};
                    if (r_cnt == DATA_LAST) begin
                        r_cnt <= '0;
                        if (BurstEn) r_addr <= r_addr + ADDR_INC;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_slave_port.sv
// Bench for bus_slave_port: serial driver tasks, memory responder and read-data monitor with expectation queues.
module tb_bus_slave_port;
    localparam int ADN = 12;
    localparam int N   = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           validIn = 1'b0, wren = 1'b0, Address = 1'b0, DataIn = 1'b0, BurstEn = 1'b0;
    logic           ready, validOut, DataOut, mem_we, mem_re;
    logic [ADN-1:0] mem_addr;
    logic [N-1:0]   mem_wdata;
    logic [N-1:0]   mem_rdata = '0;
    logic           mem_ack = 1'b0;
    logic [2:0]     state_out;

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic [ADN-1:0] a; logic [N-1:0] d; } wr_t;
    wr_t            exp_wr[$];
    logic [ADN-1:0] exp_ra[$];
    logic [N-1:0]   exp_rd[$];
    logic [N-1:0]   mem_model [0:(1<<ADN)-1];

    int       wait_cfg = 0;
    bit       tie_ack = 1'b0;
    int       wait_cnt = 0;
    int       vo_cycles = 0;
    int       rd_bits = 0;
    logic [N-1:0] rd_byte = '0;

    bus_slave_port #(.ADN(ADN), .N(N)) dut (
        .clk(clk), .reset(reset), .validIn(validIn), .wren(wren), .Address(Address),
        .DataIn(DataIn), .BurstEn(BurstEn), .ready(ready), .validOut(validOut), .DataOut(DataOut),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Memory responder: checks every request cycle against the queue head, acks after wait_cfg cycles.
    always @(negedge clk) begin
        mem_ack = tie_ack;
        total++;
        if (mem_we && mem_re) begin
            bad++;
            $display("FAIL we_re_excl: mem_we=%b mem_re=%b, required not both 1", mem_we, mem_re);
        end
        if (reset && (mem_we || mem_re)) begin
            total++;
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    bad++;
                    $display("FAIL unexp_write: addr=%h data=%h, required no write", mem_addr, mem_wdata);
                end else if (mem_addr !== exp_wr[0].a || mem_wdata !== exp_wr[0].d) begin
                    bad++;
                    $display("FAIL write_req: addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, exp_wr[0].a, exp_wr[0].d);
                end
            end else begin
                if (exp_ra.size() == 0) begin
                    bad++;
                    $display("FAIL unexp_read: addr=%h, required no read", mem_addr);
                end else if (mem_addr !== exp_ra[0]) begin
                    bad++;
                    $display("FAIL read_req: addr=%h, required %h", mem_addr, exp_ra[0]);
                end
            end
            if (tie_ack || wait_cnt >= wait_cfg) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_model[mem_addr];
                wait_cnt  = 0;
                if (mem_we) begin
                    mem_model[mem_addr] = mem_wdata;
                    if (exp_wr.size() > 0) void'(exp_wr.pop_front());
                end else if (exp_ra.size() > 0) begin
                    void'(exp_ra.pop_front());
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Read-data monitor: assembles MSB-first bytes and compares them with the expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            rd_bits = 0;
        end else if (validOut) begin
            vo_cycles++;
            rd_byte = {rd_byte[N-2:0], DataOut};
            rd_bits++;
            if (rd_bits == N) begin
                rd_bits = 0;
                total++;
                if (exp_rd.size() == 0) begin
                    bad++;
                    $display("FAIL unexp_rdata: got %h, required none", rd_byte);
                end else if (rd_byte !== exp_rd[0]) begin
                    bad++;
                    $display("FAIL rdata: got %h, required %h", rd_byte, exp_rd[0]);
                    void'(exp_rd.pop_front());
                end else begin
                    void'(exp_rd.pop_front());
                end
            end
        end else if (rd_bits != 0) begin
            total++;
            bad++;
            $display("FAIL rdata_gap: validOut dropped after %0d bits, required %0d consecutive", rd_bits, N);
            rd_bits = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic send_addr(input bit wr, input logic [ADN-1:0] a, input bit burst,
                             input int stall_at, input int stall_len);
        logic [ADN-1:0] part;
        for (int i = 0; i < ADN; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    validIn = 1'b0;
                    Address = ~Address;
                    part = a >> (ADN - i);
                    total++;
                    if (mem_addr !== part) begin
                        bad++;
                        $display("FAIL stall_shift: mem_addr=%h, required %h", mem_addr, part);
                    end
                end
            end
            @(negedge clk);
            validIn = 1'b1;
            Address = a[ADN-1-i];
            wren    = (i == 0) ? wr : ~wr;
            BurstEn = burst;
        end
    endtask

    task automatic send_data(input logic [N-1:0] d);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            validIn = 1'b1;
            DataIn  = d[N-1-i];
        end
    endtask

    task automatic end_drive();
        @(negedge clk);
        validIn = 1'b0;
        Address = 1'b0;
        DataIn  = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (state_out !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (state_out !== s) begin
            bad++;
            $display("FAIL %s: state_out=%0d after %0d cycles, required %0d", name, state_out, n, s);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        total += 6;
        if (ready !== 1'b1)     begin bad++; $display("FAIL rst_ready: got %b, required 1", ready); end
        if (validOut !== 1'b0)  begin bad++; $display("FAIL rst_validOut: got %b, required 0", validOut); end
        if (DataOut !== 1'b0)   begin bad++; $display("FAIL rst_DataOut: got %b, required 0", DataOut); end
        if ({mem_we, mem_re} !== 2'b00) begin bad++; $display("FAIL rst_req: we/re=%b, required 00", {mem_we, mem_re}); end
        if ({mem_addr, mem_wdata} !== '0) begin bad++; $display("FAIL rst_bus: addr=%h wdata=%h, required 0", mem_addr, mem_wdata); end
        if (state_out !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d, required 0", state_out); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        wait_cfg = 2;
        exp_wr.push_back('{a: 12'h0A5, d: 8'h3C});
        send_addr(1'b1, 12'h0A5, 1'b0, -1, 0);
        send_data(8'h3C);
        end_drive();
        total++;
        if (mem_we !== 1'b1) begin bad++; $display("FAIL wr_req_issued: mem_we=%b, required 1", mem_we); end
        wait_state(3'd0, 20, "wr_idle");
        total += 2;
        if (ready !== 1'b1) begin bad++; $display("FAIL wr_ready: got %b, required 1", ready); end
        if (exp_wr.size() != 0) begin bad++; $display("FAIL wr_done: %0d writes pending, required 0", exp_wr.size()); end
    endtask

    task automatic test_single_read();
        int vo0;
        wait_cfg = 3;
        mem_model[12'h123] = 8'hA5;
        exp_ra.push_back(12'h123);
        exp_rd.push_back(8'hA5);
        vo0 = vo_cycles;
        send_addr(1'b0, 12'h123, 1'b0, -1, 0);
        end_drive();
        wait_state(3'd0, 40, "rd_idle");
        @(negedge clk);
        total += 2;
        if (vo_cycles - vo0 != N) begin bad++; $display("FAIL rd_vo_count: got %0d, required %0d", vo_cycles - vo0, N); end
        if (exp_ra.size() + exp_rd.size() != 0) begin bad++; $display("FAIL rd_done: %0d pending, required 0", exp_ra.size() + exp_rd.size()); end
    endtask

    task automatic test_stall();
        wait_cfg = 0;
        exp_wr.push_back('{a: 12'h5C3, d: 8'h96});
        send_addr(1'b1, 12'h5C3, 1'b0, 5, 4);
        send_data(8'h96);
        end_drive();
        wait_state(3'd0, 20, "stall_idle");
        total++;
        if (exp_wr.size() != 0) begin bad++; $display("FAIL stall_done: %0d writes pending, required 0", exp_wr.size()); end
    endtask

    task automatic test_burst_wrap();
        wait_cfg = 1;
        exp_wr.push_back('{a: 12'hFFF, d: 8'h11});
        exp_wr.push_back('{a: 12'h000, d: 8'h22});
        send_addr(1'b1, 12'hFFF, 1'b1, -1, 0);
        send_data(8'h11);
        end_drive();
        wait_state(3'd2, 20, "burst_wdata");
        send_data(8'h22);
        end_drive();
        BurstEn = 1'b0;
        wait_state(3'd0, 20, "burst_idle");
        total++;
        if (exp_wr.size() != 0) begin bad++; $display("FAIL burst_done: %0d writes pending, required 0", exp_wr.size()); end
    endtask

    task automatic test_read_burst();
        int seen = 0, cyc = 0, first = -1, last = -1;
        tie_ack = 1'b1;
        mem_model[12'h010] = 8'h5A;
        mem_model[12'h011] = 8'hC3;
        mem_model[12'h012] = 8'h81;
        for (int k = 0; k < 3; k++) begin
            exp_ra.push_back(12'h010 + 12'(k));
            exp_rd.push_back(mem_model[12'h010 + 12'(k)]);
        end
        send_addr(1'b0, 12'h010, 1'b1, -1, 0);
        end_drive();
        while (cyc < 200 && !(state_out === 3'd0 && seen > 0)) begin
            @(negedge clk);
            cyc++;
            if (validOut) begin
                seen++;
                if (first < 0) first = cyc;
                last = cyc;
                if (seen == 2 * N + 1) BurstEn = 1'b0;
            end
        end
        tie_ack = 1'b0;
        total += 4;
        if (state_out !== 3'd0) begin bad++; $display("FAIL rb_idle: state_out=%0d, required 0", state_out); end
        if (seen != 3 * N) begin bad++; $display("FAIL rb_vo_count: got %0d, required %0d", seen, 3 * N); end
        if (last - first != 3 * N + 1) begin bad++; $display("FAIL rb_span: got %0d, required %0d", last - first, 3 * N + 1); end
        if (exp_ra.size() + exp_rd.size() != 0) begin bad++; $display("FAIL rb_done: %0d pending, required 0", exp_ra.size() + exp_rd.size()); end
    endtask

    task automatic test_reset_read();
        int seen = 0, cyc = 0;
        wait_cfg = 0;
        mem_model[12'h200] = 8'h77;
        exp_ra.push_back(12'h200);
        exp_rd.push_back(8'h77);
        send_addr(1'b0, 12'h200, 1'b0, -1, 0);
        end_drive();
        while (seen < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (validOut) seen++;
        end
        total++;
        if (seen != 4) begin bad++; $display("FAIL rr_reach: saw %0d bits, required 4", seen); end
        reset = 1'b0;
        #1;
        total += 6;
        if (validOut !== 1'b0)  begin bad++; $display("FAIL rr_validOut: got %b, required 0", validOut); end
        if (DataOut !== 1'b0)   begin bad++; $display("FAIL rr_DataOut: got %b, required 0", DataOut); end
        if (state_out !== 3'd0) begin bad++; $display("FAIL rr_state: got %0d, required 0", state_out); end
        if (ready !== 1'b1)     begin bad++; $display("FAIL rr_ready: got %b, required 1", ready); end
        if ({mem_we, mem_re} !== 2'b00) begin bad++; $display("FAIL rr_req: we/re=%b, required 00", {mem_we, mem_re}); end
        if ({mem_addr, mem_wdata} !== '0) begin bad++; $display("FAIL rr_bus: addr=%h wdata=%h, required 0", mem_addr, mem_wdata); end
        total++;
        if (exp_rd.size() != 1) begin bad++; $display("FAIL rr_pending: %0d pending, required 1", exp_rd.size()); end
        exp_rd.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_cfg = 2;
        mem_model[12'h001] = 8'h3E;
        exp_ra.push_back(12'h001);
        exp_rd.push_back(8'h3E);
        send_addr(1'b0, 12'h001, 1'b0, -1, 0);
        end_drive();
        wait_state(3'd0, 40, "rr_next_idle");
        @(negedge clk);
        total++;
        if (exp_ra.size() + exp_rd.size() != 0) begin bad++; $display("FAIL rr_next_done: %0d pending, required 0", exp_ra.size() + exp_rd.size()); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_stall();
        test_burst_wrap();
        test_read_burst();
        test_reset_read();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_slave_port.md
BUS_SLAVE_PORT -- requirements
Module: bus_slave_port

Interface
REQ-001 SHALL have parameter ADN, default 12, meaning the address width in bits.
REQ-002 SHALL have parameter N, default 8, meaning the data width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port validIn  input  1  marks a valid serial bit on Address/DataIn from the arbiter.
REQ-006 SHALL have port wren  input  1  transaction type (1 = write, 0 = read), sampled on the first address bit.
REQ-007 SHALL have port Address  input  1  serial address, MSB first.
REQ-008 SHALL have port DataIn  input  1  serial write data, MSB first.
REQ-009 SHALL have port BurstEn  input  1  burst continue request.
REQ-010 SHALL have port ready  output  1  port idle and able to accept a new transaction.
REQ-011 SHALL have port validOut  output  1  marks a valid serial read-data bit on DataOut.
REQ-012 SHALL have port DataOut  output  1  serial read data, MSB first.
REQ-013 SHALL have port mem_addr  output  ADN  parallel address to the memory.
REQ-014 SHALL have port mem_wdata  output  N  parallel write data to the memory.
REQ-015 SHALL have port mem_we  output  1  write request to the memory.
REQ-016 SHALL have port mem_re  output  1  read request to the memory.
REQ-017 SHALL have port mem_rdata  input  N  memory read data, valid when mem_ack=1.
REQ-018 SHALL have port mem_ack  input  1  memory completion for the current request.
REQ-019 SHALL have port state_out  output  3  current FSM state encoding.

Function
REQ-020 SHALL implement the states IDLE=0, ADDR=1, WDATA=2, MEMREQ=3, RDATA=4; other encodings recover to IDLE on the next clock.
REQ-021 IDLE: ready=1; validIn=1 shall capture the first Address bit, latch wren and BurstEn, set the bit count to 1, and move to ADDR.
REQ-022 ADDR: ready=0; each cycle with validIn=1 shall shift in one Address bit; validIn=0 shall stall with no shift; after ADN total bits the FSM shall go to WDATA if wren=1, else to MEMREQ.
REQ-023 WDATA: each cycle with validIn=1 shall shift in one DataIn bit (validIn=0 stalls); after N bits the FSM shall go to MEMREQ.
REQ-024 MEMREQ: mem_we (write) or mem_re (read) shall be asserted with mem_addr/mem_wdata held stable until the cycle mem_ack=1 is sampled, and deasserted on the following cycle; mem_we and mem_re shall never both be 1.
REQ-025 On a read ack, mem_rdata shall be captured and the FSM shall go to RDATA; mem_ack in the first MEMREQ cycle (zero wait) is legal.
REQ-026 RDATA: validOut=1 for exactly N consecutive cycles, DataOut carrying the captured byte MSB first; validOut=0 otherwise.
REQ-027 Burst: BurstEn shall be resampled on the write-ack cycle and on the last RDATA bit; if 1, mem_addr shall increment by 1 modulo 2^ADN (0xFFF wraps to 0x000) and the FSM shall go to WDATA for a write or MEMREQ for a read; if 0, the FSM shall go to IDLE.
REQ-028 Inputs in MEMREQ and RDATA other than mem_ack/mem_rdata/BurstEn shall be ignored.
REQ-029 ready shall be 1 only in IDLE, combinationally derived from state.

Reset
REQ-030 reset=0 shall immediately force state IDLE, ready=1, validOut=0, DataOut=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, bit counter=0, and state_out=0.
REQ-031 Reset asserted mid-transaction shall abandon it without a memory request; after release the port shall accept a new transaction on the first validIn.

Verification
REQ-032 Single write: wren=1, address 0x0A5, data 0x3C with validIn continuous -> mem_we=1, mem_addr=0x0A5, mem_wdata=0x3C until ack, then IDLE with ready=1.
REQ-033 Single read: address 0x123, mem_rdata=0xA5 with ack after 3 wait cycles -> validOut high for 8 cycles, DataOut=1,0,1,0,0,1,0,1.
REQ-034 Stall: validIn dropped for 4 cycles mid-address -> no shift during the gap; final mem_addr is still correct.
REQ-035 Write burst wrap: start at 0xFFF, BurstEn=1 for 2 beats (data 0x11, 0x22) -> writes to 0xFFF then 0x000, then IDLE.
REQ-036 Zero-wait read burst: start at 0x010, mem_ack tied 1, BurstEn=1 for 3 beats -> reads 0x010, 0x011, 0x012 back-to-back, 24 validOut cycles.
REQ-037 Reset during a read: reset=0 at the 4th RDATA bit -> validOut=0 at once; state_out=0; next read of 0x001 completes normally.
